alu4_arbiter: RTL and testbench
===============================

Name: alu4_arbiter

Overview:
Shares one 4-bit ALU datapath between two requesters (port 0 and port 1) using round-robin arbitration. Each requester has a valid/ready request channel. The requester that wins the grant has its operation executed and registered. The result goes out on one shared response channel, tagged with the requester ID. Only one operation is in flight at a time. The block sits between the ALU users in npc and the ALU4 function set.

Parameters:
- CNT_W, 8, width of the completed-operation counter (wraps).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  op code (encoding below)
- req0_a, req0_b  in  4 each  operands
- req0_cin  in  1  carry-in (used by add only)
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_cin  same as port 0, for requester 1
- rsp_valid  out  1  response holds a completed result
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that owns the response
- rsp_result  out  4  result
- rsp_zero, rsp_overflow, rsp_carry, rsp_size  out  1 each  flags
- busy  out  1  state != IDLE
- op_count  out  CNT_W  number of responses consumed, mod 2^CNT_W

Behaviour:
- Op encoding:
  - 000 add: {carry,result} = a+b+cin; overflow = signed overflow.
  - 001 sub: result = a+~b+1, cin ignored; carry = carry-out (1 means no borrow); overflow = signed overflow.
  - 010: result = ~a.
  - 011: result = a&b.
  - 100: result = a|b.
  - 101: result = a^b.
  - 110 signed less-than: result = a-b; size = result[3]^overflow (1 means a<b signed).
  - 111 equal: result = a-b; size = (a==b).
- Flags:
  - zero = (result==0) for every op.
  - carry and overflow are 0 for ops 010–101.
  - carry and overflow for 110 and 111 follow the sub rules.
  - size is 0 for ops 000–101.
- States: IDLE, RESP.
- IDLE:
  - grant = the requester whose valid is high.
  - If both are valid, grant = rr_ptr.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. Never both high.
  - On accept: compute the ALU result combinationally from the granted inputs and register result, flags and id. Set rr_ptr = ~granted_id. Go to RESP.
  - If no request is valid, rr_ptr is unchanged.
- RESP:
  - rsp_valid = 1.
  - rsp_* outputs are stable until the handshake.
  - On rsp_valid && rsp_ready: op_count++ (wraps at 2^CNT_W), go to IDLE.
  - No request is accepted in RESP. The ready signals are 0.
- Latency and throughput:
  - Accept in cycle N gives rsp_valid in cycle N+1.
  - Best-case throughput is one op per 2 cycles: accept, then response consumed, then the next accept in IDLE.
- Reset state (all outputs and state):
  - state = IDLE, rr_ptr = 0
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, all flags = 0
  - op_count = 0, busy = 0, req*_ready = 0
- Reset mid-operation: a pending response is discarded and is not counted.
- Boundaries:
  - Request inputs are sampled only at the accept edge. Later changes do not affect the stored response.
  - A requester that drops valid before it is granted loses nothing.
  - op_count increments only on a consumed response, never on accept.
  - rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Reset, then req0: add a=7, b=1, cin=0 → accept cycle 1. Next cycle: rsp_valid=1, id=0, result=8, overflow=1, carry=0, zero=0.
- req1: sub a=3, b=3, held with rsp_ready=0 for 3 cycles → rsp_valid and outputs stay constant, req0_ready and req1_ready stay 0, op_count stays 0. Then rsp_ready=1 → result=0, zero=1, carry=1; op_count becomes 1.
- Both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1 (rr_ptr starts at 0). Four responses in 8 cycles with rsp_id 0,1,0,1.
- req0 op 110: a=4'b1000 (−8), b=1 → size=1, overflow=1. Then op 111: a=5, b=5 → size=1, zero=1. Then op 111: a=5, b=6 → size=0.
- Logic ops on a=1100, b=1010: 010 → 0011, 011 → 1000, 100 → 1110, 101 → 0110. In all four cases carry=overflow=size=0.
- rst asserted while in RESP → next cycle: rsp_valid=0, busy=0, op_count unchanged-from-reset (0), rr_ptr=0. Issue 256 ops with CNT_W=8 → op_count wraps to 0.

Source files
------------

// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one 4-bit ALU between two requesters with
// round-robin arbitration and a single registered, ID-tagged response.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   reqN_valid/ready      request handshake for requester N (0, 1)
//   reqN_op, reqN_a/b     3-bit op code, 4-bit operands
//   reqN_cin              carry-in, used by add only
//   rsp_valid/ready       response handshake
//   rsp_id                requester that owns the response
//   rsp_result            4-bit result
//   rsp_zero/overflow/
//   rsp_carry/size        result flags
//   busy                  a response is pending
//   op_count              consumed responses, wraps at 2^CNT_W
module alu4_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_carry,
    output logic             rsp_size,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic       rr_ptr;
    logic       grant;
    logic       any_valid;
    logic       accept;

    logic [2:0] g_op;
    logic [3:0] g_a;
    logic [3:0] g_b;
    logic       g_cin;

    logic [4:0] add_sum;
    logic [4:0] sub_sum;
    logic       add_v;
    logic       sub_v;

    logic [3:0] alu_res;
    logic       alu_c;
    logic       alu_v;
    logic       alu_s;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        unique case ({req1_valid, req0_valid})
            2'b11:   grant = rr_ptr;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    assign g_op  = grant ? req1_op  : req0_op;
    assign g_a   = grant ? req1_a   : req0_a;
    assign g_b   = grant ? req1_b   : req0_b;
    assign g_cin = grant ? req1_cin : req0_cin;

    assign add_sum = {1'b0, g_a} + {1'b0, g_b} + {4'b0, g_cin};
    assign sub_sum = {1'b0, g_a} + {1'b0, ~g_b} + 5'd1;

    // Signed overflow: operands agree (add) or differ (sub) in sign
    // and the result sign departs from a.
    assign add_v = (g_a[3] == g_b[3]) && (add_sum[3] != g_a[3]);
    assign sub_v = (g_a[3] != g_b[3]) && (sub_sum[3] != g_a[3]);

    always_comb begin
        alu_res = 4'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_s   = 1'b0;
        unique case (g_op)
            3'b000: begin
                alu_res = add_sum[3:0];
                alu_c   = add_sum[4];
                alu_v   = add_v;
            end
            3'b001: begin
                alu_res = sub_sum[3:0];
                alu_c   = sub_sum[4];
                alu_v   = sub_v;
            end
            3'b010: alu_res = ~g_a;
            3'b011: alu_res = g_a & g_b;
            3'b100: alu_res = g_a | g_b;
            3'b101: alu_res = g_a ^ g_b;
            3'b110: begin
                alu_res = sub_sum[3:0];
                alu_c   = sub_sum[4];
                alu_v   = sub_v;
                alu_s   = sub_sum[3] ^ sub_v;
            end
            3'b111: begin
                alu_res = sub_sum[3:0];
                alu_c   = sub_sum[4];
                alu_v   = sub_v;
                alu_s   = (g_a == g_b);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = any_valid && !grant && req0_valid;
                req1_ready = any_valid &&  grant && req1_valid;
                if (any_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign accept    = req0_ready | req1_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 4'd0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_size     <= 1'b0;
            op_count     <= '0;
        end else begin
            if (accept) begin
                rr_ptr       <= ~grant;
                rsp_id       <= grant;
                rsp_result   <= alu_res;
                rsp_zero     <= (alu_res == 4'd0);
                rsp_overflow <= alu_v;
                rsp_carry    <= alu_c;
                rsp_size     <= alu_s;
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu4_arbiter.sv
// tb_alu4_arbiter: directed and random stimulus for alu4_arbiter,
// checked each cycle against a transaction-level reference model.
module tb_alu4_arbiter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0v, r1v;
    logic             r0rdy, r1rdy;
    logic [2:0]       r0op, r1op;
    logic [3:0]       r0a, r0b, r1a, r1b;
    logic             r0c, r1c;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [3:0]       rsp_result;
    logic             rsp_zero, rsp_overflow, rsp_carry, rsp_size;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending flag, last winner, captured response.
    bit       m_busy;
    int       m_last;
    int       m_id;
    int       m_count;
    logic [7:0] m_rsp;

    always #5 clk = ~clk;

    alu4_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_op(r0op),
        .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_op(r1op),
        .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
        .rsp_size(rsp_size), .busy(busy), .op_count(op_count)
    );

    // Returns {size, carry, overflow, zero, result} from integer arithmetic.
    function automatic logic [7:0] ref_alu(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic cin);
        int ua, ub, sa, sb, s, sr;
        logic [3:0] res;
        logic c, v, sz;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        res = 4'd0; c = 1'b0; v = 1'b0; sz = 1'b0;
        case (op)
            3'd0: begin
                s   = ua + ub + int'(cin);
                res = 4'(s % 16);
                c   = (s > 15);
                sr  = sa + sb + int'(cin);
                v   = (sr > 7) || (sr < -8);
            end
            3'd1, 3'd6, 3'd7: begin
                res = 4'((ua - ub + 16) % 16);
                c   = (ua >= ub);
                sr  = sa - sb;
                v   = (sr > 7) || (sr < -8);
                if (op == 3'd6) sz = (sa < sb);
                if (op == 3'd7) sz = (ua == ub);
            end
            3'd2: res = 4'(15 - ua);
            3'd3: res = a & b;
            3'd4: res = a | b;
            default: res = a ^ b;
        endcase
        return {sz, c, v, (res == 4'd0), res};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rsp_bundle();
        return {rsp_size, rsp_carry, rsp_overflow, rsp_zero, rsp_result};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_last  = 1;
        m_id    = 0;
        m_count = 0;
        m_rsp   = 8'h00;
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic cycle();
        int  g;
        bit  any;
        #1;
        any = r0v || r1v;
        if (r0v && r1v) g = (m_last == 0) ? 1 : 0;
        else            g = r1v ? 1 : 0;
        check("req0_ready", 32'(r0rdy), 32'(!m_busy && any && g == 0));
        check("req1_ready", 32'(r1rdy), 32'(!m_busy && any && g == 1));
        check("busy", 32'(busy), 32'(m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_busy));
        check("op_count", 32'(op_count), 32'(m_count % (1 << CNT_W)));
        if (m_busy) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_bundle", 32'(rsp_bundle()), 32'(m_rsp));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_busy && any) begin
            m_busy = 1'b1;
            m_last = g;
            m_id   = g;
            m_rsp  = (g == 1) ? ref_alu(r1op, r1a, r1b, r1c)
                              : ref_alu(r0op, r0a, r0b, r0c);
        end else if (m_busy && rsp_ready) begin
            m_busy = 1'b0;
            m_count++;
        end
        #1;
    endtask

    task automatic scramble();
        r0op = 3'($urandom); r0a = 4'($urandom); r0b = 4'($urandom);
        r1op = 3'($urandom); r1a = 4'($urandom); r1b = 4'($urandom);
        r0c  = 1'($urandom); r1c = 1'($urandom);
    endtask

    task automatic idle_inputs();
        r0v = 1'b0;
        r1v = 1'b0;
        scramble();
    endtask

    task automatic drive(input int port, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic cin);
        scramble();
        r0v = (port == 0);
        r1v = (port == 1);
        if (port == 0) begin
            r0op = op; r0a = a; r0b = b; r0c = cin;
        end else begin
            r1op = op; r1a = a; r1b = b; r1c = cin;
        end
    endtask

    // Issue one op, capture the registered response, then consume it.
    task automatic do_op(input int port, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic cin, output logic [7:0] got);
        rsp_ready = 1'b0;
        drive(port, op, a, b, cin);
        cycle();
        idle_inputs();
        got = rsp_bundle();
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    logic [7:0] got;
    int         cnt_before;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        rst = 1'b0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_bundle", 32'(rsp_bundle()), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'({r0rdy, r1rdy}), 32'd0);

        // add 7+1 on port 0
        drive(0, 3'b000, 4'd7, 4'd1, 1'b0);
        cycle();
        idle_inputs();
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_id", 32'(rsp_id), 32'd0);
        check("add_bundle", 32'(rsp_bundle()), 32'h28);
        cycle();
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;

        // sub 3-3 on port 1, held with both requesters pushing
        drive(1, 3'b001, 4'd3, 4'd3, 1'b1);
        cycle();
        cnt_before = int'(op_count);
        for (int i = 0; i < 3; i++) begin
            scramble();
            r0v = 1'b1;
            r1v = 1'b1;
            cycle();
            check("hold_ready", 32'({r0rdy, r1rdy}), 32'd0);
            check("hold_count", 32'(op_count), 32'(cnt_before));
        end
        idle_inputs();
        check("sub_bundle", 32'(rsp_bundle()), 32'h50);
        rsp_ready = 1'b1;
        cycle();
        check("sub_count", 32'(op_count), 32'(cnt_before + 1));

        // both valid, consumer always ready: grants alternate
        r0v = 1'b1; r0op = 3'b000; r0a = 4'd2; r0b = 4'd3; r0c = 1'b0;
        r1v = 1'b1; r1op = 3'b101; r1a = 4'd5; r1b = 4'd3; r1c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_id", 32'(rsp_id), 32'(i % 2));
            cycle();
        end
        idle_inputs();
        rsp_ready = 1'b0;

        // compare ops and logic ops
        do_op(0, 3'b110, 4'b1000, 4'd1, 1'b0, got);
        check("slt_neg8_1", 32'(got), 32'hE7);
        do_op(0, 3'b111, 4'd5, 4'd5, 1'b0, got);
        check("eq_5_5", 32'(got), 32'hD0);
        do_op(0, 3'b111, 4'd5, 4'd6, 1'b0, got);
        check("eq_5_6", 32'(got), 32'h0F);
        do_op(1, 3'b010, 4'b1100, 4'b1010, 1'b1, got);
        check("not", 32'(got), 32'h03);
        do_op(0, 3'b011, 4'b1100, 4'b1010, 1'b1, got);
        check("and", 32'(got), 32'h08);
        do_op(1, 3'b100, 4'b1100, 4'b1010, 1'b1, got);
        check("or", 32'(got), 32'h0E);
        do_op(0, 3'b101, 4'b1100, 4'b1010, 1'b1, got);
        check("xor", 32'(got), 32'h06);

        // reset while a response is pending
        drive(0, 3'b000, 4'd1, 4'd1, 1'b0);
        cycle();
        idle_inputs();
        rst = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        rst = 1'b0;
        rsp_ready = 1'b0;
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(op_count), 32'd0);
        r0v = 1'b1;
        r1v = 1'b1;
        cycle();
        idle_inputs();
        check("midrst_rr", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        cycle();

        // 256 consumed ops wrap the counter
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(int'($urandom_range(1)), 3'($urandom), 4'($urandom),
                  4'($urandom), 1'($urandom));
            rsp_ready = 1'b1;
            cycle();
            idle_inputs();
            cycle();
            if (i == 254) check("count_255", 32'(op_count), 32'd255);
        end
        check("count_wrap", 32'(op_count), 32'd0);

        // random traffic, back-pressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            scramble();
            r0v = 1'($urandom);
            r1v = 1'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(63) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
